// File: rtl/sdft_sched_pkg.sv
// Shared types and sizing helpers for the sdft tick scheduler.
package sdft_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        GUARD = 2'd2
    } state_t;

    // Watchdog budget: the sweep takes N cycles plus a few cycles of handshake slack.
    function automatic int wdog_limit(input int n);
        return n + 4;
    endfunction

    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sdft_sample_fifo.sv
// Synchronous sample FIFO with clear; head word is read combinationally.
module sdft_sample_fifo
    import sdft_sched_pkg::*;
#(
    parameter int DW    = 16,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      srst,
    input  logic                      clear,
    input  logic                      push,
    input  logic                      pop,
    input  logic [DW-1:0]             din,
    output logic [DW-1:0]             dout,
    output logic                      full,
    output logic                      empty,
    output logic [level_w(DEPTH)-1:0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = level_w(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;

    always_ff @(posedge clk) begin
        if (srst || clear) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + (AW+1)'(1);
            if (pop)  rptr <= rptr + (AW+1)'(1);
        end
    end

    // Storage is not reset; a clear only moves the pointers.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wptr[AW-1:0]] <= din;
    end

    assign level = LW'(wptr - rptr);
    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);
    assign dout  = mem[rptr[AW-1:0]];

endmodule

// File: rtl/sdft_tick_scheduler.sv
// Paces samples into an sdft: one tick per finished sweep, FIFO-buffered input.
// Statistics outputs (drop count, peak fill) exist only when SDFT_SCHED_STATS_EN is defined.
module sdft_tick_scheduler
    import sdft_sched_pkg::*;
#(
    parameter int N          = 4048,
    parameter int DW         = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int GUARD      = 2,
    parameter int CNTW       = 16
) (
    input  logic                           clk_i,
    input  logic                           srst_i,
    input  logic [DW-1:0]                  s_data_i,
    input  logic                           s_valid_i,
    output logic                           s_ready_o,
    input  logic                           flush_i,
    output logic                           tick_o,
    output logic [DW-1:0]                  data_o,
    input  logic                           eob_i,
    output logic                           busy_o,
    output logic                           warm_o,
    output logic                           timeout_o,
    output logic [CNTW-1:0]                drop_cnt_o,
    output logic [level_w(FIFO_DEPTH)-1:0] max_fill_o,
    output state_t                         state_o
);
    localparam int     LW         = level_w(FIFO_DEPTH);
    localparam int     WDOG_LIMIT = wdog_limit(N);
    localparam int     WW         = cnt_w(WDOG_LIMIT);
    localparam int     GW         = cnt_w(GUARD);
    localparam int     GL         = (GUARD > 0) ? GUARD - 1 : 0;
    localparam int     MW         = cnt_w(N);
    localparam state_t AFTER_RUN  = (GUARD == 0) ? IDLE : sdft_sched_pkg::GUARD;

    state_t        state;
    logic [WW-1:0] wdog;
    logic [GW-1:0] gcnt;
    logic [MW-1:0] warm_cnt;
    logic [DW-1:0] head;
    logic          full;
    logic          empty;
    logic [LW-1:0] level;
    logic          push;
    logic          pop;

    // Upstream cannot stall: whatever arrives while full is counted as a drop.
    assign push      = s_valid_i && !full;
    assign pop       = (state == IDLE) && !empty && !flush_i;
    assign s_ready_o = !full;

    sdft_sample_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk_i),
        .srst  (srst_i),
        .clear (flush_i),
        .push  (push),
        .pop   (pop),
        .din   (s_data_i),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state     <= IDLE;
            tick_o    <= 1'b0;
            data_o    <= '0;
            wdog      <= '0;
            gcnt      <= '0;
            timeout_o <= 1'b0;
        end else begin
            tick_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        data_o <= head;
                        tick_o <= 1'b1;
                        wdog   <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (eob_i) begin
                        gcnt  <= '0;
                        state <= AFTER_RUN;
                    end else if (wdog == WW'(WDOG_LIMIT)) begin
                        timeout_o <= 1'b1;
                        gcnt      <= '0;
                        state     <= AFTER_RUN;
                    end else begin
                        wdog <= wdog + WW'(1);
                    end
                end
                sdft_sched_pkg::GUARD: begin
                    if (gcnt == GW'(GL)) state <= IDLE;
                    else                 gcnt  <= gcnt + GW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Counts ticks actually presented, so warm_o rises the cycle after the Nth tick.
    always_ff @(posedge clk_i) begin
        if (srst_i || flush_i)                 warm_cnt <= '0;
        else if (tick_o && warm_cnt != MW'(N)) warm_cnt <= warm_cnt + MW'(1);
    end

    assign warm_o  = (warm_cnt == MW'(N));
    assign busy_o  = (state != IDLE);
    assign state_o = state;

`ifdef SDFT_SCHED_STATS_EN
    logic [CNTW-1:0] drop_cnt;
    logic [LW-1:0]   max_fill;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            drop_cnt <= '0;
            max_fill <= '0;
        end else begin
            if (s_valid_i && full && drop_cnt != '1) drop_cnt <= drop_cnt + CNTW'(1);
            if (flush_i)               max_fill <= '0;
            else if (level > max_fill) max_fill <= level;
        end
    end

    assign drop_cnt_o = drop_cnt;
    assign max_fill_o = max_fill;
`else
    logic unused_level;
    assign unused_level = ^level;
    assign drop_cnt_o   = '0;
    assign max_fill_o   = '0;
`endif

endmodule

// File: tb/tb_sdft_tick_scheduler.sv
// Scoreboard bench for sdft_tick_scheduler with a small sdft sweep model.
module tb_sdft_tick_scheduler;
    import sdft_sched_pkg::*;

    localparam int TB_N     = 8;
    localparam int TB_DW    = 16;
    localparam int TB_DEPTH = 4;
    localparam int TB_GUARD = 2;
    localparam int TB_CNTW  = 16;
    localparam int TB_LW    = $clog2(TB_DEPTH) + 1;
`ifdef SDFT_SCHED_STATS_EN
    localparam logic STATS = 1'b1;
`else
    localparam logic STATS = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                srst_i = 1'b1;
    logic [TB_DW-1:0]    s_data_i = '0;
    logic                s_valid_i = 1'b0;
    logic                s_ready_o;
    logic                flush_i = 1'b0;
    logic                tick_o;
    logic [TB_DW-1:0]    data_o;
    logic                eob_i = 1'b0;
    logic                busy_o;
    logic                warm_o;
    logic                timeout_o;
    logic [TB_CNTW-1:0]  drop_cnt_o;
    logic [TB_LW-1:0]    max_fill_o;
    state_t              state_o;

    logic [TB_DW-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int tick_cnt = 0;
    int last_tick = -1;
    logic [TB_DW-1:0] held = '0;
    logic prev_rst = 1'b1;
    logic sdft_en = 1'b1;
    logic sweep = 1'b0;
    int scnt = 0;

    sdft_tick_scheduler #(
        .N(TB_N), .DW(TB_DW), .FIFO_DEPTH(TB_DEPTH), .GUARD(TB_GUARD), .CNTW(TB_CNTW)
    ) dut (
        .clk_i      (clk),
        .srst_i     (srst_i),
        .s_data_i   (s_data_i),
        .s_valid_i  (s_valid_i),
        .s_ready_o  (s_ready_o),
        .flush_i    (flush_i),
        .tick_o     (tick_o),
        .data_o     (data_o),
        .eob_i      (eob_i),
        .busy_o     (busy_o),
        .warm_o     (warm_o),
        .timeout_o  (timeout_o),
        .drop_cnt_o (drop_cnt_o),
        .max_fill_o (max_fill_o),
        .state_o    (state_o)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // sdft model: eob pulse N+1 cycles after the tick cycle
    always @(posedge clk) begin
        eob_i <= 1'b0;
        if (srst_i) begin
            sweep <= 1'b0;
        end else if (tick_o) begin
            sweep <= 1'b1;
            scnt  <= 0;
        end else if (sweep) begin
            if (scnt == TB_N - 1) begin
                sweep <= 1'b0;
                if (sdft_en) eob_i <= 1'b1;
            end else begin
                scnt <= scnt + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (prev_rst) begin
            held      = data_o;
            last_tick = -1;
        end else if (tick_o) begin
            tick_cnt++;
            if (exp_q.size() == 0) check("tick_unexpected", 32'd1, 32'd0);
            else                   check("tick_data", 32'(data_o), 32'(exp_q.pop_front()));
            if (last_tick >= 0)
                check("tick_gap_ok", 32'((cyc - last_tick) >= TB_N + 1 + TB_GUARD), 32'd1);
            last_tick = cyc;
            held      = data_o;
        end else begin
            check("data_hold", 32'(data_o), 32'(held));
        end
        prev_rst = srst_i;
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [TB_DW-1:0] d, input logic acc, input logic keep);
        s_valid_i = 1'b1;
        s_data_i  = d;
        check("s_ready", 32'(s_ready_o), 32'(acc));
        if (acc && keep) exp_q.push_back(d);
        step();
        s_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input int limit, output int n);
        n = 0;
        while (busy_o && n < limit) begin
            step();
            n++;
        end
        check("idle_reached", 32'(busy_o), 32'd0);
    endtask

    task automatic wait_ticks(input int target, input int limit);
        int n = 0;
        while (tick_cnt < target && n < limit) begin
            step();
            n++;
        end
        check("tick_count", 32'(tick_cnt), 32'(target));
    endtask

    task automatic pulse_flush();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        int n;
        int base;
        logic [TB_DW-1:0] d;

        repeat (3) step();
        srst_i = 1'b0;
        step();
        check("rst_tick", 32'(tick_o), 32'd0);
        check("rst_data", 32'(data_o), 32'd0);
        check("rst_ready", 32'(s_ready_o), 32'd1);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_warm", 32'(warm_o), 32'd0);
        check("rst_timeout", 32'(timeout_o), 32'd0);
        check("rst_drop", 32'(drop_cnt_o), 32'd0);
        check("rst_maxfill", 32'(max_fill_o), 32'd0);

        // 1: single sample, tick two cycles after acceptance
        send(16'h1234, 1'b1, 1'b1);
        check("t1_tick_t1", 32'(tick_o), 32'd0);
        step();
        check("t1_tick_t2", 32'(tick_o), 32'd1);
        check("t1_data", 32'(data_o), 32'h1234);
        check("t1_busy", 32'(busy_o), 32'd1);
        wait_idle(4 * TB_N, n);
        check("t1_busy_len", 32'(n), 32'(TB_N + 4));

        // 2: burst of 6, the last one dropped
        base = tick_cnt;
        for (int i = 0; i < 6; i++) send(16'($urandom_range(0, 65535)), i < 5, 1'b1);
        wait_ticks(base + 5, 5 * (TB_N + 5) + 30);
        wait_idle(4 * TB_N, n);
        check("t2_queue_empty", 32'(exp_q.size()), 32'd0);
        check("t2_drop", 32'(drop_cnt_o), STATS ? 32'd1 : 32'd0);
        check("t2_maxfill", 32'(max_fill_o), STATS ? 32'd4 : 32'd0);

        // 3: warm-up after flush
        pulse_flush();
        check("t3_warm_clr", 32'(warm_o), 32'd0);
        check("t3_maxfill_clr", 32'(max_fill_o), 32'd0);
        for (int i = 1; i <= TB_N + 1; i++) begin
            send(16'($urandom_range(0, 65535)), 1'b1, 1'b1);
            step();
            check("t3_tick", 32'(tick_o), 32'd1);
            check("t3_warm_at_tick", 32'(warm_o), 32'(i > TB_N));
            step();
            check("t3_warm_after", 32'(warm_o), 32'(i >= TB_N));
            wait_idle(4 * TB_N, n);
        end

        // 4: missing eob -> watchdog timeout, then next tick
        sdft_en = 1'b0;
        send(16'h0a0a, 1'b1, 1'b1);
        send(16'h0b0b, 1'b1, 1'b1);
        check("t4_tick", 32'(tick_o), 32'd1);
        repeat (TB_N + 4) step();
        check("t4_timeout_before", 32'(timeout_o), 32'd0);
        check("t4_state_run", 32'(state_o), 32'(RUN));
        step();
        check("t4_timeout_set", 32'(timeout_o), 32'd1);
        check("t4_state_guard", 32'(state_o), 32'(sdft_sched_pkg::GUARD));
        sdft_en = 1'b1;
        repeat (3) step();
        check("t4_next_tick", 32'(tick_o), 32'd1);
        wait_idle(4 * TB_N, n);
        check("t4_timeout_sticky", 32'(timeout_o), 32'd1);

        // 5: flush mid-RUN with 3 queued; coincident push discarded
        send(16'h5001, 1'b1, 1'b1);
        send(16'h5002, 1'b1, 1'b1);
        send(16'h5003, 1'b1, 1'b1);
        send(16'h5004, 1'b1, 1'b1);
        flush_i = 1'b1;
        send(16'h5005, 1'b1, 1'b0);
        flush_i = 1'b0;
        exp_q.delete();
        check("t5_warm_clr", 32'(warm_o), 32'd0);
        check("t5_busy", 32'(busy_o), 32'd1);
        base = tick_cnt;
        wait_idle(4 * TB_N, n);
        repeat (2 * (TB_N + 5)) step();
        check("t5_no_tick", 32'(tick_cnt), 32'(base));
        check("t5_warm_low", 32'(warm_o), 32'd0);

        // 6: reset mid-RUN
        d = 16'h8000 | 16'($urandom_range(1, 32767));
        send(d, 1'b1, 1'b1);
        step();
        check("t6_tick", 32'(tick_o), 32'd1);
        repeat (3) step();
        srst_i = 1'b1;
        step();
        srst_i = 1'b0;
        exp_q.delete();
        check("t6_tick", 32'(tick_o), 32'd0);
        check("t6_data", 32'(data_o), 32'd0);
        check("t6_busy", 32'(busy_o), 32'd0);
        check("t6_warm", 32'(warm_o), 32'd0);
        check("t6_timeout", 32'(timeout_o), 32'd0);
        check("t6_ready", 32'(s_ready_o), 32'd1);
        check("t6_drop", 32'(drop_cnt_o), 32'd0);
        check("t6_maxfill", 32'(max_fill_o), 32'd0);
        send(16'h6789, 1'b1, 1'b1);
        step();
        check("t6_tick_after", 32'(tick_o), 32'd1);
        wait_idle(4 * TB_N, n);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
